shift_engine: RTL and testbench
===============================

// Module: shift_engine
// PURPOSE
//   Parametrised multi-mode sequential shifter. Loads a WIDTH-bit word and
//   shifts it one bit per clock, for a programmed number of steps.
//   Supports logical, arithmetic and rotate modes.
//   Reports the last bit shifted out and a sticky OR of all bits shifted out.
//   Uses a start/busy/done handshake. Serves as the shift datapath for the
//   ALU and the serial-arithmetic blocks.
// PARAMETERS
//   WIDTH  8  data word width in bits (>=2)
//   CNT_W  4  width of the shift-amount field; amounts 0..2**CNT_W-1 allowed
// PORTS
//   clk        in   1       clock; all state changes on the rising edge
//   clr        in   1       reset, synchronous, active-high
//   start      in   1       request an operation; sampled only in IDLE
//   load_data  in   WIDTH   operand, captured when start is accepted
//   amount     in   CNT_W   number of single-bit steps, captured with start
//   mode       in   3       shift mode, captured with start
//   data       in   1       serial fill bit for LSL/LSR, sampled on every SHIFT edge
//   so         out  WIDTH   shift register contents
//   busy       out  1       high whenever the state is not IDLE
//   done       out  1       one-cycle pulse; so/oflow/sticky are final
//   oflow      out  1       last bit shifted out
//   sticky     out  1       OR of every bit shifted out during the operation
// BEHAVIOUR
//   Reset:
//   - clr=1 at an edge: state=IDLE, so=0, oflow=0, sticky=0, cnt=0.
//   - busy=0 and done=0 in the following cycle.
//   - clr has priority over everything, including start.
//   - clr during SHIFT or DONE aborts the operation; no done pulse is produced.
//   State machine:
//   - States: IDLE -> SHIFT -> DONE -> IDLE; busy=(state!=IDLE), done=(state==DONE).
//   - IDLE with start=1:
//     - so<=load_data, cnt<=amount, mode latched, oflow<=0, sticky<=0.
//     - Next state is SHIFT if amount!=0, else DONE.
//   - IDLE with start=0: hold all registers; so keeps its last result.
//   - SHIFT, each edge: perform one step, cnt<=cnt-1.
//     - If cnt==1, the next state is DONE.
//   - DONE: outputs hold for the one done cycle; next state is IDLE unconditionally.
//   - start while busy is ignored: not queued, no effect.
//   - start is accepted again on the first IDLE cycle.
//   - Latency: start edge + amount SHIFT edges, so done is high in cycle amount+1
//     after the start edge. amount=0 gives done in cycle 1 with so=load_data.
//   Modes (latched; ob = bit shifted out):
//   - 000 LSL: so<={so[W-2:0],data}; ob=so[W-1]
//   - 001 LSR: so<={data,so[W-1:1]}; ob=so[0]
//   - 010 ASR: so<={so[W-1],so[W-1:1]}; ob=so[0]
//   - 011 ROL: so<={so[W-2:0],so[W-1]}; ob=so[W-1]
//   - 100 ROR: so<={so[0],so[W-1:1]}; ob=so[0]
//   - 101..111 reserved: so, oflow and sticky hold, but cnt still counts down
//     and done still fires.
//   Flag update on each SHIFT edge (valid modes): oflow<=ob, sticky<=sticky|ob.
//   Amount boundaries:
//   - amount>=WIDTH is legal. LSL/LSR fully replace the word with fill bits.
//   - ASR saturates to all sign bits.
//   - Rotates wrap, so amount=WIDTH returns the original word.
//   - The counter never underflows: SHIFT is never entered with cnt=0.
// TESTING
//   1. clr=1 one edge mid-idle -> so=0, busy=0, done=0, oflow=0, sticky=0.
//   2. LSL, load_data=8'b1001_0110, amount=3, data=1 -> so=8'b1011_0111, oflow=0,
//      sticky=1, done 4 cycles after the start edge.
//   3. ASR, load_data=8'b1000_0001, amount=2 -> so=8'b1110_0000, oflow=0, sticky=1.
//   4. ROR, load_data=8'hA5, amount=8 -> so=8'hA5, sticky=1, done at cycle 9.
//      Repeat with LSR, amount=12, data=0 -> so=8'h00.
//   5. amount=0, load_data=8'h3C -> done in cycle 1, so=8'h3C, oflow=0, sticky=0.
//      Pulse start during busy of a 5-step op -> ignored, single done, result
//      unchanged.
//   6. clr=1 on the 2nd SHIFT edge of a 6-step LSL -> next cycle IDLE, so=0,
//      no done. Then a new start runs normally.

Source files
------------

// File: rtl/shift_engine.sv
`default_nettype none
// ============================================================================
// Module      : shift_engine
// Description : Multi-mode sequential shifter. Loads a WIDTH-bit word and
//               shifts it one bit per clock for a programmed number of
//               steps (LSL, LSR, ASR, ROL, ROR). Tracks the last bit shifted
//               out and a sticky OR of all bits shifted out. Uses a
//               start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_engine #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] load_data,
    input  logic [CNT_W-1:0] amount,
    input  logic [2:0]       mode,
    input  logic             data,
    output logic [WIDTH-1:0] so,
    output logic             busy,
    output logic             done,
    output logic             oflow,
    output logic             sticky
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    localparam logic [2:0] c_LSL = 3'b000;
    localparam logic [2:0] c_LSR = 3'b001;
    localparam logic [2:0] c_ASR = 3'b010;
    localparam logic [2:0] c_ROL = 3'b011;
    localparam logic [2:0] c_ROR = 3'b100;

    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_mode;
    logic [WIDTH-1:0] r_so;
    logic             r_oflow;
    logic             r_sticky;

    logic [WIDTH-1:0] w_shift_so;
    logic             w_ob;
    logic             w_valid;

    // One-step shift result and the bit leaving the word for the latched mode
    always_comb begin
        w_shift_so = r_so;
        w_ob       = 1'b0;
        w_valid    = 1'b1;
        case (r_mode)
            c_LSL: begin
                w_shift_so = {r_so[WIDTH-2:0], data};
                w_ob       = r_so[WIDTH-1];
            end
            c_LSR: begin
                w_shift_so = {data, r_so[WIDTH-1:1]};
                w_ob       = r_so[0];
            end
            c_ASR: begin
                w_shift_so = {r_so[WIDTH-1], r_so[WIDTH-1:1]};
                w_ob       = r_so[0];
            end
            c_ROL: begin
                w_shift_so = {r_so[WIDTH-2:0], r_so[WIDTH-1]};
                w_ob       = r_so[WIDTH-1];
            end
            c_ROR: begin
                w_shift_so = {r_so[0], r_so[WIDTH-1:1]};
                w_ob       = r_so[0];
            end
            default: w_valid = 1'b0;  // reserved: word and flags hold
        endcase
    end

    // Control FSM and datapath registers; clr aborts any operation in flight
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state  <= c_IDLE;
            r_so     <= '0;
            r_oflow  <= 1'b0;
            r_sticky <= 1'b0;
            r_cnt    <= '0;
            r_mode   <= c_LSL;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_so     <= load_data;
                        r_cnt    <= amount;
                        r_mode   <= mode;
                        r_oflow  <= 1'b0;
                        r_sticky <= 1'b0;
                        // A zero amount skips SHIFT so the counter never wraps
                        r_state  <= (amount != '0) ? c_SHIFT : c_DONE;
                    end
                end
                c_SHIFT: begin
                    if (w_valid) begin
                        r_so     <= w_shift_so;
                        r_oflow  <= w_ob;
                        r_sticky <= r_sticky | w_ob;
                    end
                    r_cnt <= r_cnt - c_CNT_ONE;
                    if (r_cnt == c_CNT_ONE) begin
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign so     = r_so;
    assign busy   = (r_state != c_IDLE);
    assign done   = (r_state == c_DONE);
    assign oflow  = r_oflow;
    assign sticky = r_sticky;

endmodule
`default_nettype wire

// File: tb/tb_shift_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_engine
// Description : Self-checking bench for shift_engine (WIDTH=8, CNT_W=4).
//               Directed cases followed by random operations compared
//               against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_engine;

    logic       clk;
    logic       clr;
    logic       start;
    logic [7:0] load_data;
    logic [3:0] amount;
    logic [2:0] mode;
    logic       data;
    logic [7:0] so;
    logic       busy;
    logic       done;
    logic       oflow;
    logic       sticky;

    int passed = 0;
    int total  = 0;

    // Reference model state
    int exp_so;
    int exp_of;
    int exp_st;

    shift_engine #(.WIDTH(8), .CNT_W(4)) dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .load_data (load_data),
        .amount    (amount),
        .mode      (mode),
        .data      (data),
        .so        (so),
        .busy      (busy),
        .done      (done),
        .oflow     (oflow),
        .sticky    (sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One shift step computed with plain integer arithmetic on an 8-bit value
    task automatic model_step(input int m, input int f);
        int v;
        int ob;
        v  = exp_so;
        ob = 0;
        case (m)
            0: begin ob = v / 128; v = (v * 2 + f) % 256;            end
            1: begin ob = v % 2;   v = v / 2 + f * 128;              end
            2: begin ob = v % 2;   v = v / 2 + ((v >= 128) ? 128 : 0); end
            3: begin ob = v / 128; v = (v * 2) % 256 + ob;           end
            4: begin ob = v % 2;   v = v / 2 + ob * 128;             end
            default: return;
        endcase
        exp_so = v;
        exp_of = ob;
        exp_st = (exp_st != 0 || ob != 0) ? 1 : 0;
    endtask

    // Runs one operation from an IDLE negedge; checks busy/done every cycle.
    // fill_mode: 0/1 constant fill bit, 2 random fill per step.
    // busy_start_at: cycle (>=1) at which a spurious start is pulsed, 0 = none.
    task automatic run_op(input int m, input int ld, input int amt,
                          input int fill_mode, input int busy_start_at);
        int f;
        @(negedge clk);
        start     = 1'b1;
        load_data = ld[7:0];
        amount    = amt[3:0];
        mode      = m[2:0];
        data      = (fill_mode == 1);
        exp_so = ld; exp_of = 0; exp_st = 0;
        @(negedge clk);
        for (int c = 1; c <= amt + 1; c++) begin
            start = 1'b0;
            chk($sformatf("busy c%0d", c), int'(busy), 1);
            chk($sformatf("done c%0d", c), int'(done), (c == amt + 1) ? 1 : 0);
            if (c == amt + 1) begin
                chk("so final", int'(so), exp_so);
                chk("oflow final", int'(oflow), exp_of);
                chk("sticky final", int'(sticky), exp_st);
            end else begin
                f = (fill_mode == 2) ? int'($urandom_range(1, 0)) : fill_mode;
                data = f[0];
                model_step(m, f);
                if (c == busy_start_at) begin
                    start     = 1'b1;
                    load_data = 8'($urandom);
                    amount    = 4'($urandom);
                    mode      = 3'($urandom);
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("busy after done", int'(busy), 0);
        chk("done after done", int'(done), 0);
        chk("so held", int'(so), exp_so);
    endtask

    initial begin
        clr = 1'b1; start = 1'b0; load_data = '0; amount = '0; mode = '0; data = 1'b0;
        repeat (2) @(negedge clk);
        clr = 1'b0;
        chk("reset so", int'(so), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);

        // LSL 1001_0110 by 3 with fill 1 -> 1011_0111
        run_op(0, 8'b1001_0110, 3, 1, 0);
        chk("lsl3 so", int'(so), 8'b1011_0111);
        chk("lsl3 sticky", int'(sticky), 1);

        // clr for one edge mid-idle
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        chk("idle clr so", int'(so), 0);
        chk("idle clr busy", int'(busy), 0);
        chk("idle clr done", int'(done), 0);
        chk("idle clr oflow", int'(oflow), 0);
        chk("idle clr sticky", int'(sticky), 0);

        // ASR 1000_0001 by 2 -> 1110_0000
        run_op(2, 8'b1000_0001, 2, 0, 0);
        chk("asr2 so", int'(so), 8'hE0);
        chk("asr2 oflow", int'(oflow), 0);
        chk("asr2 sticky", int'(sticky), 1);

        // ROR A5 by 8 returns the word; LSR by 12 with fill 0 clears it
        run_op(4, 8'hA5, 8, 0, 0);
        chk("ror8 so", int'(so), 8'hA5);
        chk("ror8 sticky", int'(sticky), 1);
        run_op(1, 8'hA5, 12, 0, 0);
        chk("lsr12 so", int'(so), 8'h00);

        // Zero amount passes the operand straight through
        run_op(0, 8'h3C, 0, 1, 0);
        chk("amt0 so", int'(so), 8'h3C);
        chk("amt0 oflow", int'(oflow), 0);
        chk("amt0 sticky", int'(sticky), 0);

        // Start pulsed while busy is ignored
        run_op(3, 8'h5A, 5, 0, 2);

        // Reserved mode holds the word but still completes
        run_op(6, 8'hC3, 4, 2, 0);
        chk("reserved so", int'(so), 8'hC3);

        // clr on the 2nd SHIFT edge of a 6-step LSL aborts with no done
        @(negedge clk);
        start = 1'b1; load_data = 8'hF0; amount = 4'd6; mode = 3'b000; data = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        chk("abort so", int'(so), 0);
        chk("abort busy", int'(busy), 0);
        chk("abort oflow", int'(oflow), 0);
        chk("abort sticky", int'(sticky), 0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("abort no done %0d", i), int'(done), 0);
            @(negedge clk);
        end
        run_op(0, 8'h81, 2, 1, 0);
        chk("post abort so", int'(so), 8'h07);

        // Random operations against the reference model
        for (int n = 0; n < 40; n++) begin
            run_op(int'($urandom_range(7, 0)), int'($urandom_range(255, 0)),
                   int'($urandom_range(15, 0)), 2,
                   ($urandom_range(3, 0) == 0) ? 1 : 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
